counter_run_ctrl: RTL and testbench
===================================

Name: counter_run_ctrl

Overview:
Run controller that sequences one free-running program counter datapath. It replaces the bare count-from-reset behaviour with a commanded counter. A single command port (valid/ready) loads, limits, starts, pauses, single-steps and clears the counter. The controller reports completion and wraps, and sits between a host/sequencer and the counter instances in tb.

Parameters:
WIDTH, 32, counter and command-data width
LIMIT_RST, 32'hFFFF_FFFF, limit register value after reset
AUTO_RELOAD, 0, 1 = on limit hit reload pc from reload register and keep running; 0 = stop in DONE

Ports:
clkin  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept command this cycle
cmd_op  in  3  0 NOP, 1 LOAD, 2 SET_LIMIT, 3 START, 4 STOP, 5 STEP, 6 CLEAR, 7 reserved (treated as NOP + err)
cmd_data  in  WIDTH  operand for LOAD/SET_LIMIT
pc  out  WIDTH  current counter value
state  out  2  0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
done  out  1  one-cycle pulse on limit hit
wrap_cnt  out  8  saturating count of auto-reloads
err  out  1  one-cycle pulse on rejected/illegal command

Behaviour:
- Reset (rst=1 at posedge) sets: pc=0, limit=LIMIT_RST, reload=0, state=IDLE, done=0, err=0, wrap_cnt=0. rst overrides any command that cycle.
- Command accepted when cmd_valid & cmd_ready at posedge. Effects visible the next cycle.
- cmd_ready=1 in every cycle except the single busy cycle after an accepted STEP.
- LOAD: pc<=cmd_data, reload<=cmd_data. Legal in IDLE/PAUSE/DONE; LOAD in DONE moves to IDLE. In RUN it is ignored and pulses err.
- SET_LIMIT: limit<=cmd_data. Legal in IDLE/PAUSE/DONE; in RUN it is ignored and pulses err.
- START: IDLE/PAUSE -> RUN. Ignored with err in RUN. Ignored with err in DONE (LOAD or CLEAR required first).
- STOP: RUN -> PAUSE, and pc does not increment in the accept cycle. In other states it is a NOP without err.
- STEP: legal in IDLE/PAUSE only. If pc!=limit, pc<=pc+1; if pc==limit, pc is unchanged and done pulses (state stays). cmd_ready=0 the following cycle. In RUN/DONE it pulses err.
- CLEAR: from any state -> IDLE, pc<=reload, wrap_cnt<=0. CLEAR has highest command priority.
- RUN per-cycle action, when no STOP/CLEAR is accepted:
  - If pc==limit: done=1 for one cycle.
  - With AUTO_RELOAD=0: state->DONE and pc holds.
  - With AUTO_RELOAD=1: pc<=reload, state stays RUN, wrap_cnt<=wrap_cnt+1 saturating at 255.
  - Otherwise pc<=pc+1, modulo 2^WIDTH.
- Simultaneous events: STOP or CLEAR accepted in the cycle pc==limit wins, with no done and no reload.
- START with pc==limit: the first RUN cycle hits the limit immediately, giving done one cycle after RUN is entered.
- Wrap: limit < pc at START means the counter rolls through 2^WIDTH-1 -> 0 and continues to limit. No err is raised.
- Latency: accept at edge N gives the new state/pc at edge N; the first increment after START happens at edge N+1.
- done and err are registered pulses and never stay high more than one cycle per event.
- Outputs are all registered; there is no combinational path from cmd_* to outputs except cmd_ready, which is state-only.

Test Plan:
- Reset mid-RUN (pc=0x25): assert rst one cycle -> pc=0, state=IDLE, limit=0xFFFFFFFF, wrap_cnt=0, done=0 on the next edge.
- LOAD 10, SET_LIMIT 13, START -> pc 10,11,12,13. done pulses exactly once on the cycle after pc reaches 13. state=DONE, pc holds at 13, START then gives err=1.
- AUTO_RELOAD=1, LOAD 5, SET_LIMIT 7, START, run 12 cycles -> pc sequence 5,6,7,5,6,7,... with done each wrap. wrap_cnt=3 after three limit hits; it saturates at 255 over a long run.
- RUN with STOP issued the same cycle pc==limit -> state=PAUSE, pc=limit, done never pulses. A following STEP pulses done with pc unchanged.
- STEP twice back-to-back from IDLE pc=0, with cmd_valid held -> cmd_ready low one cycle after each accept. pc=1 then 2, with the second STEP accepted two cycles after the first.
- LOAD and SET_LIMIT during RUN -> err pulse each, pc keeps incrementing, limit unchanged. Then LOAD 0xFFFFFFFE, SET_LIMIT 1, START -> pc 0xFFFFFFFE, 0xFFFFFFFF, 0, 1, then DONE.

Source files
------------

// File: rtl/counter_run_ctrl_if.sv
// Command interface between a host/sequencer and the counter run controller.
//   cmd_valid : host has a command this cycle
//   cmd_ready : controller can accept a command this cycle
//   cmd_op    : 0 NOP, 1 LOAD, 2 SET_LIMIT, 3 START, 4 STOP, 5 STEP, 6 CLEAR, 7 reserved
//   cmd_data  : operand for LOAD / SET_LIMIT
interface counter_run_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/counter_run_ctrl.sv
// Run controller for a commanded program counter: load, limit, start, pause,
// single-step and clear through one valid/ready command port.
//   clkin    : clock, all logic on posedge
//   rst      : synchronous active-high reset
//   cmd      : command interface (slave side)
//   pc       : current counter value
//   state    : 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
//   done     : one-cycle pulse on limit hit
//   wrap_cnt : saturating count of auto-reloads
//   err      : one-cycle pulse on rejected/illegal command
module counter_run_ctrl #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] LIMIT_RST   = {WIDTH{1'b1}},
    parameter bit               AUTO_RELOAD = 1'b0
) (
    input  logic               clkin,
    input  logic               rst,
    counter_run_ctrl_if.slave  cmd,
    output logic [WIDTH-1:0]   pc,
    output logic [1:0]         state,
    output logic               done,
    output logic [7:0]         wrap_cnt,
    output logic               err
);
    localparam int unsigned WRAP_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_LOAD      = 3'd1,
        OP_SET_LIMIT = 3'd2,
        OP_START     = 3'd3,
        OP_STOP      = 3'd4,
        OP_STEP      = 3'd5,
        OP_CLEAR     = 3'd6,
        OP_RSVD      = 3'd7
    } op_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    pc_q, pc_d;
    logic [WIDTH-1:0]    limit_q, limit_d;
    logic [WIDTH-1:0]    reload_q, reload_d;
    logic [WRAP_W-1:0]   wrap_q, wrap_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                ready_q, ready_d;
    logic                accept;
    logic                at_limit;
    logic                idle_or_pause;
    logic                run_tick;
    op_t                 op;

    assign op            = op_t'(cmd.cmd_op);
    assign accept        = cmd.cmd_valid & ready_q;
    assign at_limit      = (pc_q == limit_q);
    assign idle_or_pause = (state_q == ST_IDLE) || (state_q == ST_PAUSE);

    // State and datapath registers
    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            limit_q  <= LIMIT_RST;
            reload_q <= '0;
            wrap_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            limit_q  <= limit_d;
            reload_q <= reload_d;
            wrap_q   <= wrap_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
        end
    end

    // Command decode, run-cycle action and next-state
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        limit_d  = limit_q;
        reload_d = reload_q;
        wrap_d   = wrap_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        ready_d  = 1'b1;
        run_tick = (state_q == ST_RUN);

        if (accept) begin
            // Any accepted STEP costs one busy cycle on the command port
            if (op == OP_STEP) begin
                ready_d = 1'b0;
            end
            case (op)
                OP_NOP: begin
                end
                OP_LOAD: begin
                    if (state_q == ST_RUN) begin
                        err_d = 1'b1;
                    end else begin
                        pc_d     = cmd.cmd_data;
                        reload_d = cmd.cmd_data;
                        if (state_q == ST_DONE) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                OP_SET_LIMIT: begin
                    if (state_q == ST_RUN) begin
                        err_d = 1'b1;
                    end else begin
                        limit_d = cmd.cmd_data;
                    end
                end
                OP_START: begin
                    if (idle_or_pause) begin
                        state_d = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_STOP: begin
                    // STOP beats the run action, including a limit hit
                    if (state_q == ST_RUN) begin
                        state_d  = ST_PAUSE;
                        run_tick = 1'b0;
                    end
                end
                OP_STEP: begin
                    if (idle_or_pause) begin
                        if (at_limit) begin
                            done_d = 1'b1;
                        end else begin
                            pc_d = pc_q + WIDTH'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_CLEAR: begin
                    state_d  = ST_IDLE;
                    pc_d     = reload_q;
                    wrap_d   = '0;
                    run_tick = 1'b0;
                end
                OP_RSVD: begin
                    err_d = 1'b1;
                end
            endcase
        end

        if (run_tick) begin
            if (at_limit) begin
                done_d = 1'b1;
                if (AUTO_RELOAD) begin
                    pc_d   = reload_q;
                    wrap_d = (wrap_q == {WRAP_W{1'b1}}) ? wrap_q : wrap_q + WRAP_W'(1);
                end else begin
                    state_d = ST_DONE;
                end
            end else begin
                pc_d = pc_q + WIDTH'(1);
            end
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign pc            = pc_q;
    assign state         = state_q;
    assign done          = done_q;
    assign wrap_cnt      = wrap_q;
    assign err           = err_q;
endmodule

// File: tb/tb_counter_run_ctrl.sv
// Self-checking bench for counter_run_ctrl: one instance with AUTO_RELOAD=0 and
// one with AUTO_RELOAD=1, driven with identical commands and compared against
// a behavioural model of the command/run rules.
module tb_counter_run_ctrl;
    localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, SETL = 3'd2, START = 3'd3,
                           STOP = 3'd4, STEP = 3'd5, CLEAR = 3'd6, RSVD = 3'd7;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic        clkin = 1'b0;
    logic        rst;
    logic [31:0] pc0, pc1;
    logic [1:0]  st0, st1;
    logic        done0, done1, err0, err1;
    logic [7:0]  wrap0, wrap1;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] limit;
        logic [31:0] reload;
        int          st;
        int          wrap;
        bit          done;
        bit          err;
        bit          busy;
    } mdl_t;

    mdl_t m0, m1;

    counter_run_ctrl_if #(.WIDTH(32)) if0 ();
    counter_run_ctrl_if #(.WIDTH(32)) if1 ();

    counter_run_ctrl #(.WIDTH(32), .LIMIT_RST(32'hFFFF_FFFF), .AUTO_RELOAD(1'b0)) dut0 (
        .clkin(clkin), .rst(rst), .cmd(if0), .pc(pc0), .state(st0),
        .done(done0), .wrap_cnt(wrap0), .err(err0)
    );

    counter_run_ctrl #(.WIDTH(32), .LIMIT_RST(32'hFFFF_FFFF), .AUTO_RELOAD(1'b1)) dut1 (
        .clkin(clkin), .rst(rst), .cmd(if1), .pc(pc1), .state(st1),
        .done(done1), .wrap_cnt(wrap1), .err(err1)
    );

    always #5 clkin = ~clkin;

    // Behavioural model: one clock of the controller from the command rules
    function automatic mdl_t mstep(input mdl_t m, input bit ar, input bit rs,
                                   input bit v, input int op, input logic [31:0] d);
        mdl_t n;
        bit   acc;
        bit   run;
        n      = m;
        n.done = 1'b0;
        n.err  = 1'b0;
        n.busy = 1'b0;
        if (rs) begin
            n.pc = 32'd0; n.limit = 32'hFFFF_FFFF; n.reload = 32'd0;
            n.st = S_IDLE; n.wrap = 0;
            return n;
        end
        acc = v && !m.busy;
        run = (m.st == S_RUN);
        if (acc) begin
            n.busy = (op == 5);
            case (op)
                1: if (run) n.err = 1'b1;
                   else begin
                       n.pc = d; n.reload = d;
                       if (m.st == S_DONE) n.st = S_IDLE;
                   end
                2: if (run) n.err = 1'b1; else n.limit = d;
                3: if (m.st == S_IDLE || m.st == S_PAUSE) n.st = S_RUN; else n.err = 1'b1;
                4: if (run) begin n.st = S_PAUSE; run = 1'b0; end
                5: if (m.st == S_IDLE || m.st == S_PAUSE) begin
                       if (m.pc == m.limit) n.done = 1'b1; else n.pc = m.pc + 32'd1;
                   end else n.err = 1'b1;
                6: begin n.st = S_IDLE; n.pc = m.reload; n.wrap = 0; run = 1'b0; end
                7: n.err = 1'b1;
                default: ;
            endcase
        end
        if (run) begin
            if (m.pc == m.limit) begin
                n.done = 1'b1;
                if (ar) begin
                    n.pc   = m.reload;
                    n.wrap = (m.wrap >= 255) ? 255 : m.wrap + 1;
                end else begin
                    n.st = S_DONE;
                end
            end else begin
                n.pc = m.pc + 32'd1;
            end
        end
        return n;
    endfunction

    // Drive one cycle of stimulus to both instances, advance the model, sample at edge+1
    task automatic tick(input bit rs, input bit v, input logic [2:0] op, input logic [31:0] d);
        rst = rs;
        if0.cmd_valid = v; if0.cmd_op = op; if0.cmd_data = d;
        if1.cmd_valid = v; if1.cmd_op = op; if1.cmd_data = d;
        m0 = mstep(m0, 1'b0, rs, v, int'(op), d);
        m1 = mstep(m1, 1'b1, rs, v, int'(op), d);
        @(posedge clkin);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, NOP, 32'd0);
        checks++;
        if ({pc0, st0, done0, err0, wrap0, if0.cmd_ready} !== {32'd0, 2'd0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: pc=%h st=%0d done=%b err=%b wrap=%0d rdy=%b, need pc=0 st=0 done=0 err=0 wrap=0 rdy=1",
                     pc0, st0, done0, err0, wrap0, if0.cmd_ready);
        end
        tick(1'b0, 1'b1, LOAD, 32'h20);
        tick(1'b0, 1'b1, START, 32'd0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, NOP, 32'd0);
        checks++;
        if (pc0 !== 32'h25 || st0 !== 2'd1) begin
            errors++;
            $display("FAIL run_to_25: pc=%h st=%0d, need pc=25 st=1", pc0, st0);
        end
        tick(1'b1, 1'b1, LOAD, 32'h77);
        checks++;
        if ({pc0, st0, done0, wrap0} !== {32'd0, 2'd0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_mid_run: pc=%h st=%0d done=%b wrap=%0d, need 0/0/0/0", pc0, st0, done0, wrap0);
        end
        // Limit must be back at all-ones: a STEP from 0xFFFFFFFF hits it
        tick(1'b0, 1'b1, LOAD, 32'hFFFF_FFFF);
        tick(1'b0, 1'b1, STEP, 32'd0);
        checks++;
        if (pc0 !== 32'hFFFF_FFFF || done0 !== 1'b1 || if0.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_limit: pc=%h done=%b rdy=%b, need pc=ffffffff done=1 rdy=0", pc0, done0, if0.cmd_ready);
        end
    endtask

    task automatic test_limit_done();
        logic [31:0] exp_pc [5] = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd13};
        bit          exp_dn [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          pulses;
        tick(1'b1, 1'b0, NOP, 32'd0);
        tick(1'b0, 1'b1, LOAD, 32'd10);
        tick(1'b0, 1'b1, SETL, 32'd13);
        tick(1'b0, 1'b1, START, 32'd0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick(1'b0, 1'b0, NOP, 32'd0);
            pulses += int'(done0);
            checks++;
            if (pc0 !== exp_pc[i] || done0 !== exp_dn[i]) begin
                errors++;
                $display("FAIL limit_seq[%0d]: pc=%0d done=%b, need pc=%0d done=%b", i, pc0, done0, exp_pc[i], exp_dn[i]);
            end
        end
        checks++;
        if (st0 !== 2'd3) begin
            errors++;
            $display("FAIL limit_state: st=%0d, need 3", st0);
        end
        tick(1'b0, 1'b0, NOP, 32'd0);
        pulses += int'(done0);
        tick(1'b0, 1'b1, START, 32'd0);
        pulses += int'(done0);
        checks++;
        if (err0 !== 1'b1 || st0 !== 2'd3 || pc0 !== 32'd13 || pulses != 1) begin
            errors++;
            $display("FAIL start_in_done: err=%b st=%0d pc=%0d pulses=%0d, need err=1 st=3 pc=13 pulses=1",
                     err0, st0, pc0, pulses);
        end
    endtask

    task automatic test_auto_reload();
        logic [31:0] epc;
        tick(1'b1, 1'b0, NOP, 32'd0);
        tick(1'b0, 1'b1, LOAD, 32'd5);
        tick(1'b0, 1'b1, SETL, 32'd7);
        tick(1'b0, 1'b1, START, 32'd0);
        for (int k = 1; k <= 12; k++) begin
            tick(1'b0, 1'b0, NOP, 32'd0);
            epc = 32'd5 + 32'(k % 3);
            checks++;
            if (pc1 !== epc || done1 !== (k % 3 == 0) || wrap1 !== 8'(k / 3) || st1 !== 2'd1) begin
                errors++;
                $display("FAIL reload_seq[%0d]: pc=%0d done=%b wrap=%0d st=%0d, need pc=%0d done=%b wrap=%0d st=1",
                         k, pc1, done1, wrap1, st1, epc, (k % 3 == 0), k / 3);
            end
        end
        for (int k = 0; k < 800; k++) tick(1'b0, 1'b0, NOP, 32'd0);
        checks++;
        if (wrap1 !== 8'd255) begin
            errors++;
            $display("FAIL wrap_saturate: wrap=%0d, need 255", wrap1);
        end
    endtask

    task automatic test_stop_at_limit();
        bit seen_done;
        tick(1'b1, 1'b0, NOP, 32'd0);
        tick(1'b0, 1'b1, LOAD, 32'd3);
        tick(1'b0, 1'b1, SETL, 32'd5);
        tick(1'b0, 1'b1, START, 32'd0);
        tick(1'b0, 1'b0, NOP, 32'd0);
        tick(1'b0, 1'b0, NOP, 32'd0);
        tick(1'b0, 1'b1, STOP, 32'd0);
        seen_done = done0;
        tick(1'b0, 1'b0, NOP, 32'd0);
        seen_done |= done0;
        checks++;
        if (st0 !== 2'd2 || pc0 !== 32'd5 || seen_done) begin
            errors++;
            $display("FAIL stop_at_limit: st=%0d pc=%0d done_seen=%b, need st=2 pc=5 done_seen=0", st0, pc0, seen_done);
        end
        tick(1'b0, 1'b1, STEP, 32'd0);
        checks++;
        if (done0 !== 1'b1 || pc0 !== 32'd5 || st0 !== 2'd2) begin
            errors++;
            $display("FAIL step_at_limit: done=%b pc=%0d st=%0d, need done=1 pc=5 st=2", done0, pc0, st0);
        end
    endtask

    task automatic test_back_to_back_step();
        logic [31:0] exp_pc [4] = '{32'd1, 32'd1, 32'd2, 32'd2};
        logic        exp_rd [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        tick(1'b1, 1'b0, NOP, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, (i < 3), STEP, 32'd0);
            checks++;
            if (pc0 !== exp_pc[i] || if0.cmd_ready !== exp_rd[i]) begin
                errors++;
                $display("FAIL b2b_step[%0d]: pc=%0d rdy=%b, need pc=%0d rdy=%b", i, pc0, if0.cmd_ready, exp_pc[i], exp_rd[i]);
            end
        end
    endtask

    task automatic test_run_errors_and_wrap();
        logic [31:0] exp_pc [5] = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd1, 32'd1};
        logic [1:0]  exp_st [5] = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd3};
        tick(1'b1, 1'b0, NOP, 32'd0);
        tick(1'b0, 1'b1, SETL, 32'd100);
        tick(1'b0, 1'b1, START, 32'd0);
        tick(1'b0, 1'b0, NOP, 32'd0);
        tick(1'b0, 1'b1, LOAD, 32'd50);
        checks++;
        if (err0 !== 1'b1 || pc0 !== 32'd2) begin
            errors++;
            $display("FAIL load_in_run: err=%b pc=%0d, need err=1 pc=2", err0, pc0);
        end
        tick(1'b0, 1'b1, SETL, 32'd3);
        checks++;
        if (err0 !== 1'b1 || pc0 !== 32'd3) begin
            errors++;
            $display("FAIL setl_in_run: err=%b pc=%0d, need err=1 pc=3", err0, pc0);
        end
        tick(1'b0, 1'b0, NOP, 32'd0);
        checks++;
        if (err0 !== 1'b0 || done0 !== 1'b0 || pc0 !== 32'd4 || st0 !== 2'd1) begin
            errors++;
            $display("FAIL limit_unchanged: err=%b done=%b pc=%0d st=%0d, need 0/0/4/1", err0, done0, pc0, st0);
        end
        tick(1'b0, 1'b1, STOP, 32'd0);
        tick(1'b0, 1'b1, LOAD, 32'hFFFF_FFFE);
        tick(1'b0, 1'b1, SETL, 32'd1);
        tick(1'b0, 1'b1, START, 32'd0);
        checks++;
        if (pc0 !== 32'hFFFF_FFFE || st0 !== 2'd1 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_start: pc=%h st=%0d err=%b, need fffffffe/1/0", pc0, st0, err0);
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, NOP, 32'd0);
            checks++;
            if (pc0 !== exp_pc[i] || st0 !== exp_st[i] || err0 !== 1'b0 || done0 !== (i == 3)) begin
                errors++;
                $display("FAIL wrap_seq[%0d]: pc=%h st=%0d err=%b done=%b, need pc=%h st=%0d err=0 done=%b",
                         i, pc0, st0, err0, done0, exp_pc[i], exp_st[i], (i == 3));
            end
        end
    endtask

    task automatic test_clear_reserved();
        tick(1'b1, 1'b0, NOP, 32'd0);
        tick(1'b0, 1'b1, LOAD, 32'd9);
        tick(1'b0, 1'b1, START, 32'd0);
        tick(1'b0, 1'b0, NOP, 32'd0);
        tick(1'b0, 1'b0, NOP, 32'd0);
        tick(1'b0, 1'b1, CLEAR, 32'd0);
        checks++;
        if (st0 !== 2'd0 || pc0 !== 32'd9 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL clear_run: st=%0d pc=%0d err=%b, need 0/9/0", st0, pc0, err0);
        end
        tick(1'b0, 1'b1, RSVD, 32'd0);
        checks++;
        if (err0 !== 1'b1 || st0 !== 2'd0 || pc0 !== 32'd9) begin
            errors++;
            $display("FAIL reserved_op: err=%b st=%0d pc=%0d, need 1/0/9", err0, st0, pc0);
        end
        tick(1'b0, 1'b0, NOP, 32'd0);
        checks++;
        if (err0 !== 1'b0) begin
            errors++;
            $display("FAIL err_one_cycle: err=%b, need 0", err0);
        end
    endtask

    task automatic test_random();
        bit          rs, v;
        logic [2:0]  op;
        logic [31:0] d;
        tick(1'b1, 1'b0, NOP, 32'd0);
        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(0, 299) == 0);
            v  = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else                           d = 32'($urandom_range(0, 24));
            tick(rs, v, op, d);
            checks++;
            if ({pc0, st0, done0, err0, wrap0, if0.cmd_ready} !==
                {m0.pc, 2'(m0.st), m0.done, m0.err, 8'(m0.wrap), !m0.busy}) begin
                errors++;
                $display("FAIL rand0[%0d]: pc=%h st=%0d dn=%b er=%b wr=%0d rd=%b, need pc=%h st=%0d dn=%b er=%b wr=%0d rd=%b",
                         i, pc0, st0, done0, err0, wrap0, if0.cmd_ready,
                         m0.pc, m0.st, m0.done, m0.err, m0.wrap, !m0.busy);
            end
            checks++;
            if ({pc1, st1, done1, err1, wrap1, if1.cmd_ready} !==
                {m1.pc, 2'(m1.st), m1.done, m1.err, 8'(m1.wrap), !m1.busy}) begin
                errors++;
                $display("FAIL rand1[%0d]: pc=%h st=%0d dn=%b er=%b wr=%0d rd=%b, need pc=%h st=%0d dn=%b er=%b wr=%0d rd=%b",
                         i, pc1, st1, done1, err1, wrap1, if1.cmd_ready,
                         m1.pc, m1.st, m1.done, m1.err, m1.wrap, !m1.busy);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        if0.cmd_valid = 1'b0; if0.cmd_op = NOP; if0.cmd_data = 32'd0;
        if1.cmd_valid = 1'b0; if1.cmd_op = NOP; if1.cmd_data = 32'd0;
        test_reset();
        test_limit_done();
        test_auto_reload();
        test_stop_at_limit();
        test_back_to_back_step();
        test_run_errors_and_wrap();
        test_clear_reserved();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
